// File: rtl/bcd_to_bin_seq.sv
// Purpose: sequential packed-BCD to unsigned binary converter, one digit per clock, MSD first.
// Latency: done pulses DIGITS cycles after the edge that accepts start; busy is high DIGITS+1 cycles.
// Backpressure: none; start is only sampled in IDLE, so a request while busy is dropped.
// Ports: clk/rst_n (async active-low); start + bcd_in request a conversion (digit k at [4k+3:4k]);
//        busy = not idle; done = one-cycle completion pulse; bin_out/err hold the last result
//        (bin_out forced to 0 when any digit was > 9).
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [4*DIGITS-1:0]   shift_q, shift_d;
  logic [BIN_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_flag_q, err_flag_d;
  logic [BIN_W-1:0]      bin_out_q, bin_out_d;
  logic                  err_q, err_d;

  logic [3:0]            digit;
  logic [BIN_W+3:0]      acc_x10;
  logic [BIN_W+3:0]      acc_sum;
  logic [BIN_W-1:0]      acc_next;
  logic                  err_any;

  // Datapath for one digit step: acc*10 + d, widened by 4 bits then truncated.
  always_comb begin
    digit    = shift_q[4*DIGITS-1 -: 4];
    acc_x10  = ({4'b0000, acc_q} << 3) + ({4'b0000, acc_q} << 1);
    acc_sum  = acc_x10 + (BIN_W + 4)'(digit);
    acc_next = acc_sum[BIN_W-1:0];
    err_any  = err_flag_q | (digit > 4'd9);
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    err_flag_d = err_flag_q;
    bin_out_d  = bin_out_q;
    err_d      = err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = CONV;
          shift_d    = bcd_in;
          acc_d      = '0;
          cnt_d      = CNT_W'(DIGITS - 1);
          err_flag_d = 1'b0;
        end
      end
      CONV: begin
        acc_d      = acc_next;
        shift_d    = shift_q << 4;
        err_flag_d = err_any;
        cnt_d      = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          // Last digit: publish result; an invalid digit anywhere zeroes the value.
          state_d   = DONE;
          bin_out_d = err_any ? '0 : acc_next;
          err_d     = err_any;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      err_flag_q <= 1'b0;
      bin_out_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      err_flag_q <= err_flag_d;
      bin_out_q  <= bin_out_d;
      err_q      <= err_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign bin_out = bin_out_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Bench for bcd_to_bin_seq: a 4-digit and a 2-digit instance share clock and reset.
// Expected results are queued when a conversion is started and compared on each done pulse.
module tb_bcd_to_bin_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic [15:0] bcd_a;
  logic [7:0]  bcd_b;
  logic        busy_a, done_a, err_a;
  logic        busy_b, done_b, err_b;
  logic [13:0] bin_a;
  logic [6:0]  bin_b;

  typedef struct {
    logic [13:0] bin;
    logic        err;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int total = 0;
  int bad   = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  logic [13:0] prev_bin_a;
  logic        prev_err_a;

  always #5 clk = ~clk;

  bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bcd_in(bcd_a),
    .busy(busy_a), .done(done_a), .bin_out(bin_a), .err(err_a)
  );

  bcd_to_bin_seq #(.DIGITS(2), .BIN_W(7)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bcd_in(bcd_b),
    .busy(busy_b), .done(done_b), .bin_out(bin_b), .err(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Scoreboard / monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (done_a) begin
      done_cnt_a++;
      if (q_a.size() == 0) chk("a_spurious_done", 1, 0);
      else begin
        e = q_a.pop_front();
        chk("a_bin", bin_a, e.bin);
        chk("a_err", err_a, e.err);
      end
    end else if (rst_n && (bin_a !== prev_bin_a || err_a !== prev_err_a)) begin
      chk("a_hold", {bin_a, err_a}, {prev_bin_a, prev_err_a});
    end
    prev_bin_a = bin_a;
    prev_err_a = err_a;
    if (done_b) begin
      done_cnt_b++;
      if (q_b.size() == 0) chk("b_spurious_done", 1, 0);
      else begin
        e = q_b.pop_front();
        chk("b_bin", bin_b, e.bin);
        chk("b_err", err_b, e.err);
      end
    end
  end

  // One conversion with a single-cycle start pulse; checks latency and busy width.
  task automatic run_conv(input bit sel, input logic [15:0] bcd, input logic [13:0] eb, input logic ee);
    int nd;
    int lat;
    int busy_n;
    nd = sel ? 2 : 4;
    lat = 0;
    busy_n = 0;
    @(negedge clk);
    if (sel) begin
      bcd_b = bcd[7:0]; start_b = 1'b1; q_b.push_back('{eb, ee});
    end else begin
      bcd_a = bcd; start_a = 1'b1; q_a.push_back('{eb, ee});
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      if (sel ? busy_b : busy_a) busy_n++;
      if (sel ? done_b : done_a) begin
        lat = i;
        break;
      end
    end
    chk(sel ? "b_latency" : "a_latency", lat, nd + 1);
    chk(sel ? "b_busy_cycles" : "a_busy_cycles", busy_n, nd + 1);
    @(negedge clk);
    chk(sel ? "b_busy_after" : "a_busy_after", sel ? busy_b : busy_a, 0);
    chk(sel ? "b_done_after" : "a_done_after", sel ? done_b : done_a, 0);
  endtask

  initial begin
    int t[3];
    int dc;
    int saved;
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    bcd_a   = '0;
    bcd_b   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_bin", bin_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_b_bin", bin_b, 0);
    rst_n = 1'b1;

    run_conv(0, 16'h1234, 14'd1234, 1'b0);
    run_conv(0, 16'h9999, 14'd9999, 1'b0);
    run_conv(0, 16'h0000, 14'd0,    1'b0);
    run_conv(0, 16'h12A4, 14'd0,    1'b1);
    run_conv(0, 16'h0042, 14'd42,   1'b0);

    // start held high: one result every DIGITS+2 cycles; bcd_in wiggles during CONV.
    @(negedge clk);
    start_a = 1'b1;
    bcd_a   = 16'h0507;
    repeat (3) q_a.push_back('{14'd507, 1'b0});
    dc = 0;
    for (int i = 1; i <= 40 && dc < 3; i++) begin
      @(negedge clk);
      if (i % 6 == 2) bcd_a = 16'h9999;
      if (i % 6 == 4) bcd_a = 16'h0507;
      if (done_a) begin
        t[dc] = i;
        dc++;
        if (dc == 3) start_a = 1'b0;
      end
    end
    chk("held_done_count", dc, 3);
    if (dc == 3) begin
      chk("held_period1", t[1] - t[0], 6);
      chk("held_period2", t[2] - t[1], 6);
    end
    repeat (3) @(negedge clk);

    // Reset during CONV discards the conversion.
    saved = done_cnt_a;
    start_a = 1'b1;
    bcd_a   = 16'h8765;
    @(negedge clk);
    start_a = 1'b0;
    chk("mid_busy", busy_a, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy_a, 0);
    chk("midrst_done", done_a, 0);
    chk("midrst_bin", bin_a, 0);
    chk("midrst_err", err_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_no_done", done_cnt_a, saved);
    run_conv(0, 16'h0001, 14'd1, 1'b0);

    // Two-digit instance.
    run_conv(1, 16'h0099, 14'd99, 1'b0);
    run_conv(1, 16'h009F, 14'd0,  1'b1);
    run_conv(1, 16'h0007, 14'd7,  1'b0);

    repeat (2) @(negedge clk);
    chk("a_queue_empty", q_a.size(), 0);
    chk("b_queue_empty", q_b.size(), 0);
    chk("b_done_total", done_cnt_b, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
